// File: rtl/fifo_umbral_pkg.sv
// Shared constants for the FIFO instances (MF, VC0, VC1, D0, D1).
// The per-FIFO address widths and threshold defaults are collected here.
package fifo_umbral_pkg;

  localparam int PKG_DATA_W = 6;

  localparam int MF_ADDR_W  = 2;
  localparam int VC_ADDR_W  = 4;
  localparam int D_ADDR_W   = 2;

  localparam int MF_AE_DEF  = 1;
  localparam int MF_AF_DEF  = 3;
  localparam int VC_AE_DEF  = 4;
  localparam int VC_AF_DEF  = 12;
  localparam int D_AE_DEF   = 1;
  localparam int D_AF_DEF   = 3;

  typedef enum logic [2:0] {
    FIFO_MF  = 3'd0,
    FIFO_VC0 = 3'd1,
    FIFO_VC1 = 3'd2,
    FIFO_D0  = 3'd3,
    FIFO_D1  = 3'd4
  } fifo_id_e;

  // Occupancy decode shared by every instance; thresholds arrive zero-extended.
  function automatic logic [1:0] almost_flags(input logic [15:0] cnt,
                                              input logic [15:0] thr_ae,
                                              input logic [15:0] thr_af);
    almost_flags = {(cnt >= thr_af), (cnt <= thr_ae)};
  endfunction

endpackage

// File: rtl/fifo_umbral_if.sv
// Data/status bundle between a FIFO and the logic that pushes into and pops from it.
interface fifo_umbral_if #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 4
);

  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              fifo_empty;
  logic              fifo_full;
  logic              almost_empty;
  logic              almost_full;
  logic              fifo_error;
  logic [ADDR_W:0]   count;

  modport master (
    output push, data_in, pop,
    input  data_out, valid_out, fifo_empty, fifo_full,
           almost_empty, almost_full, fifo_error, count
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out, fifo_empty, fifo_full,
           almost_empty, almost_full, fifo_error, count
  );

endinterface

// File: rtl/fifo_umbral_mem.sv
// Storage array: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module fifo_umbral_mem #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-empty/almost-full thresholds
// and a sticky overflow/underflow error flag.
module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_W = PKG_DATA_W,
  parameter int ADDR_W = VC_ADDR_W,
  parameter int AE_DEF = VC_AE_DEF,
  parameter int AF_DEF = VC_AF_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              i_init,
  input  logic [ADDR_W-1:0] i_umbral_ae,
  input  logic [ADDR_W-1:0] i_umbral_af,
  fifo_umbral_if.slave      bus
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] W_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_ae;
  logic [ADDR_W-1:0] r_af;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid;
  logic              r_error;

  logic [DATA_W-1:0] w_rd_data;
  logic [ADDR_W:0]   w_count_nxt;
  logic              w_full;
  logic              w_empty;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic              w_fault;
  logic [1:0]        w_almost;

  fifo_umbral_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  // A full FIFO still accepts a push when the same cycle pops; an empty one never bypasses.
  always_comb begin
    w_full    = (r_count == W_DEPTH);
    w_empty   = (r_count == (ADDR_W + 1)'(0));
    w_push_ok = bus.push && (!w_full || bus.pop);
    w_pop_ok  = bus.pop && !w_empty;
    w_fault   = (bus.push && w_full && !bus.pop) || (bus.pop && w_empty);
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + (ADDR_W + 1)'(1);
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_nxt = r_count - (ADDR_W + 1)'(1);
    end else begin
      w_count_nxt = r_count;
    end
    w_almost = almost_flags(16'(r_count), 16'(r_ae), 16'(r_af));
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_ae       <= ADDR_W'(AE_DEF);
      r_af       <= ADDR_W'(AF_DEF);
    end else begin
      if (i_init) begin
        r_ae <= i_umbral_ae;
        r_af <= i_umbral_af;
      end
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
        r_data_out <= w_rd_data;
        r_valid    <= 1'b1;
      end else begin
        r_valid    <= 1'b0;
      end
      if (w_fault) begin
        r_error <= 1'b1;
      end
      r_count <= w_count_nxt;
    end
  end

  assign bus.data_out     = r_data_out;
  assign bus.valid_out    = r_valid;
  assign bus.count        = r_count;
  assign bus.fifo_error   = r_error;
  assign bus.fifo_empty   = w_empty;
  assign bus.fifo_full    = w_full;
  assign bus.almost_empty = w_almost[0];
  assign bus.almost_full  = w_almost[1];

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed bench for fifo_umbral (DATA_W=6, ADDR_W=4, AE=4, AF=12).
module tb_fifo_umbral;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       init;
  logic [3:0] umbral_ae;
  logic [3:0] umbral_af;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_umbral_if #(.DATA_W(6), .ADDR_W(4)) bus ();

  fifo_umbral #(
    .DATA_W (6),
    .ADDR_W (4),
    .AE_DEF (4),
    .AF_DEF (12)
  ) u_dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .i_init      (init),
    .i_umbral_ae (umbral_ae),
    .i_umbral_af (umbral_af),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic psh, input logic pp, input logic [5:0] d);
    bus.push    = psh;
    bus.pop     = pp;
    bus.data_in = d;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    step();
    reset_L = 1'b1;
  endtask

  logic [5:0] q[$];
  logic [5:0] exp_d;
  logic [5:0] nd;

  initial begin
    reset_L = 1'b0; init = 1'b0; umbral_ae = 4'd0; umbral_af = 4'd0;
    drive(1'b1, 1'b1, 6'h15);
    step();
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.fifo_empty), 32'd1);
    check("rst_full", 32'(bus.fifo_full), 32'd0);
    check("rst_ae", 32'(bus.almost_empty), 32'd1);
    check("rst_af", 32'(bus.almost_full), 32'd0);
    check("rst_err", 32'(bus.fifo_error), 32'd0);
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    reset_L = 1'b1;

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b0, 6'(i));
      step();
      check("fill_count", 32'(bus.count), 32'(i));
      check("fill_af", 32'(bus.almost_full), 32'(i >= 12));
      check("fill_ae", 32'(bus.almost_empty), 32'(i <= 4));
    end
    check("fill_full", 32'(bus.fifo_full), 32'd1);
    check("fill_err", 32'(bus.fifo_error), 32'd0);

    // Overflow
    drive(1'b1, 1'b0, 6'h3F);
    step();
    check("ovf_count", 32'(bus.count), 32'd16);
    check("ovf_err", 32'(bus.fifo_error), 32'd1);

    // Drain: original data, never 0x3F
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b1, 6'h00);
      step();
      check("drain_data", 32'(bus.data_out), 32'(i));
      check("drain_valid", 32'(bus.valid_out), 32'd1);
    end
    check("drain_empty", 32'(bus.fifo_empty), 32'd1);
    drive(1'b0, 1'b0, 6'h00);
    step();
    check("idle_valid", 32'(bus.valid_out), 32'd0);
    check("idle_hold", 32'(bus.data_out), 32'h10);

    // Underflow with simultaneous push on an empty FIFO
    drive(1'b0, 1'b0, 6'h00);
    do_reset();
    drive(1'b1, 1'b1, 6'h2A);
    step();
    check("udf_count", 32'(bus.count), 32'd1);
    check("udf_err", 32'(bus.fifo_error), 32'd1);
    check("udf_valid", 32'(bus.valid_out), 32'd0);
    drive(1'b0, 1'b1, 6'h00);
    step();
    check("udf_pop_data", 32'(bus.data_out), 32'h2A);
    check("udf_pop_valid", 32'(bus.valid_out), 32'd1);
    check("udf_pop_count", 32'(bus.count), 32'd0);
    check("udf_err_sticky", 32'(bus.fifo_error), 32'd1);

    // Push+pop on a full FIFO
    drive(1'b0, 1'b0, 6'h00);
    do_reset();
    check("rst2_err", 32'(bus.fifo_error), 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 6'(33 + i));
      step();
    end
    check("full2", 32'(bus.fifo_full), 32'd1);
    drive(1'b1, 1'b1, 6'h07);
    step();
    check("pp_full_count", 32'(bus.count), 32'd16);
    check("pp_full_err", 32'(bus.fifo_error), 32'd0);
    check("pp_full_data", 32'(bus.data_out), 32'd33);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 6'h00);
      step();
      check("pp_drain", 32'(bus.data_out), (i < 15) ? 32'(34 + i) : 32'h07);
    end
    check("pp_drain_empty", 32'(bus.fifo_empty), 32'd1);

    // Threshold reprogram
    drive(1'b0, 1'b0, 6'h00);
    do_reset();
    init = 1'b1; umbral_ae = 4'd2; umbral_af = 4'd3;
    step();
    init = 1'b0;
    check("thr_count", 32'(bus.count), 32'd0);
    check("thr_ae0", 32'(bus.almost_empty), 32'd1);
    check("thr_af0", 32'(bus.almost_full), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 6'(i));
      step();
      check("thr_ae", 32'(bus.almost_empty), 32'(i <= 2));
      check("thr_af", 32'(bus.almost_full), 32'(i >= 3));
    end
    check("thr_count3", 32'(bus.count), 32'd3);

    // Pointer wrap at occupancy 5
    drive(1'b0, 1'b0, 6'h00);
    do_reset();
    q.delete();
    for (int i = 0; i < 5; i++) begin
      nd = 6'(10 + i);
      q.push_back(nd);
      drive(1'b1, 1'b0, nd);
      step();
    end
    for (int k = 0; k < 40; k++) begin
      nd = 6'(20 + k);
      exp_d = q.pop_front();
      q.push_back(nd);
      drive(1'b1, 1'b1, nd);
      step();
      check("wrap_data", 32'(bus.data_out), 32'(exp_d));
      check("wrap_count", 32'(bus.count), 32'd5);
    end
    check("wrap_err", 32'(bus.fifo_error), 32'd0);
    drive(1'b0, 1'b0, 6'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
